free_list: RTL and testbench
============================

Name: free_list

Overview:
- Free-list manager for the switch's shared packet buffer. Hands out free block indices to the write path (alloc) and takes back released indices from the read path (free).
- After reset, every block 0..NUM_BLOCKS-1 is free. Allocation is granted combinationally in the cycle it is requested. A block freed in the same cycle as an allocation on an empty list is bypassed straight to the allocator.

Parameters:
- NUM_BLOCKS, default 4096 (from mem_pkg): number of buffer blocks managed.
- ADDR_W, default 12 (from mem_pkg, equal to $clog2(NUM_BLOCKS)): block index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alloc_req_i  input  1  request one free block this cycle.
- alloc_gnt_o  output  1  grant; asserted in the same cycle as alloc_req_i when a block is available.
- alloc_block_idx_o  output  ADDR_W  granted block index; valid when alloc_gnt_o=1.
- free_req_i  input  1  return one block this cycle.
- free_block_idx_i  input  ADDR_W  index being returned.

Behaviour:
- State, all registered and cleared by async reset:
  - fresh_cnt (ADDR_W+1 bits): next never-allocated index; reset 0.
  - recycle FIFO of depth NUM_BLOCKS × ADDR_W with rd_ptr and wr_ptr (ADDR_W bits, reset 0) and count (ADDR_W+1 bits, reset 0).
- Availability: fresh_avail = (fresh_cnt < NUM_BLOCKS); fifo_avail = (count != 0).
- Source priority per cycle:
  - (1) fresh counter;
  - (2) FIFO head;
  - (3) bypass, used when alloc_req_i and free_req_i are both high and neither (1) nor (2) is available.
- alloc_gnt_o = alloc_req_i & (fresh_avail | fifo_avail | free_req_i). Combinational, zero latency.
- alloc_block_idx_o = the selected source's index when alloc_gnt_o=1; drives 0 when alloc_gnt_o=0.
- Ordering after reset: allocations return 0, 1, 2, … NUM_BLOCKS-1 in order. After that, recycled blocks return in FIFO (free) order.
- Rising edge with grant from fresh: fresh_cnt increments.
- Rising edge with grant from FIFO: rd_ptr increments (wraps modulo NUM_BLOCKS) and count decrements.
- free_req_i without bypass: free_block_idx_i is written at wr_ptr, wr_ptr increments (wraps modulo NUM_BLOCKS), and count increments.
- Simultaneous FIFO pop and push: count stays unchanged; both pointers advance.
- Bypass cycle: no FIFO write or pointer change. The freed index is consumed directly; count and fresh_cnt are unchanged.
- Exhausted (fresh done, FIFO empty, no free): alloc_gnt_o=0, no state change.
- Overflow: a free when count==NUM_BLOCKS is dropped. This can only happen on a double free. No index validity or duplicate checking is done; the caller must only free allocated blocks.
- alloc_req_i with no grant has no side effects. Requesters retry in a later cycle.
- Reset is asynchronous and may be asserted mid-operation. It restores the all-free state immediately, and outputs go to alloc_gnt_o=0, alloc_block_idx_o=0. FIFO memory contents need no reset.
- Throughput: one alloc and one free per cycle, sustained.

Decomposition:
- mem_pkg holds NUM_BLOCKS, ADDR_W and a block_idx_t typedef (logic [ADDR_W-1:0]). It is shared with the buffer memory and the switch datapath.
- One natural sub-module: fl_fifo, a synchronous single-clock FIFO (push/pop/count, simultaneous push+pop). It is instantiated for the recycle queue; the fresh counter and source selection stay in free_list.

Test Plan:
- Reset, then NUM_BLOCKS single-cycle allocs (req high one cycle, low one cycle) -> each grant=1, indices 0,1,…,4095 in order.
- One further alloc on the exhausted list -> alloc_gnt_o=0, no state change.
- Free idx 2048, then alloc -> grant=1, idx=2048. A following alloc -> grant=0.
- Empty list, alloc_req_i=1 and free_req_i=1 with idx 1200 in the same cycle -> grant=1, alloc idx=1200. The next alloc -> grant=0, confirming the FIFO stayed empty.
- Empty list, free 5, 9, 3 on successive cycles, then three allocs -> 5, 9, 3. Then a simultaneous free 7 + alloc with FIFO non-empty -> returns FIFO head, and 7 is returned by the next alloc.
- Assert rst_n mid-sequence after ~10 allocs -> outputs go to 0 immediately. After deassertion, allocs restart at 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared buffer-memory geometry: block count, index width and the block index type.
// Used by the free-list manager, the buffer memory and the switch datapath.
package mem_pkg;

  localparam int NUM_BLOCKS = 4096;
  localparam int ADDR_W     = $clog2(NUM_BLOCKS);

  typedef logic [ADDR_W-1:0] block_idx_t;

endpackage

// File: rtl/fl_fifo.sv
// Single-clock FIFO with first-word fall-through read, used as the recycle queue
// for released block indices. Pushes to a full FIFO and pops from an empty one are ignored.
module fl_fifo #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 12,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i  & ~empty_o;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; entries are only read after being written, and a reset
  // clears the pointers and count, which is what marks the contents invalid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/free_list.sv
// Free-list manager for the shared packet buffer: grants free block indices with zero
// latency from a fresh counter, then a recycle FIFO, then a same-cycle bypass of a freed block.
module free_list #(
  parameter int NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
  parameter int ADDR_W     = mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req_i,
  output logic              alloc_gnt_o,
  output logic [ADDR_W-1:0] alloc_block_idx_o,
  input  logic              free_req_i,
  input  logic [ADDR_W-1:0] free_block_idx_i
);

  localparam logic [ADDR_W:0] NUM_BLOCKS_C = (ADDR_W + 1)'(NUM_BLOCKS);

  logic [ADDR_W:0]   fresh_cnt_q, fresh_cnt_d;
  logic [ADDR_W-1:0] fifo_head;
  logic              fifo_empty, fifo_full;
  logic              fresh_avail, fifo_avail;
  logic              sel_fresh, sel_fifo, sel_bypass;
  logic              fifo_push, fifo_pop;

  assign fresh_avail = (fresh_cnt_q < NUM_BLOCKS_C);
  assign fifo_avail  = ~fifo_empty;

  // Grant is gated by rst_n so outputs read idle for the whole reset window,
  // even if a requester keeps alloc_req_i high across it.
  assign sel_fresh  = rst_n & alloc_req_i & fresh_avail;
  assign sel_fifo   = rst_n & alloc_req_i & ~fresh_avail & fifo_avail;
  assign sel_bypass = rst_n & alloc_req_i & ~fresh_avail & ~fifo_avail & free_req_i;

  assign alloc_gnt_o = sel_fresh | sel_fifo | sel_bypass;

  always_comb begin
    alloc_block_idx_o = '0;
    if (sel_fresh)       alloc_block_idx_o = fresh_cnt_q[ADDR_W-1:0];
    else if (sel_fifo)   alloc_block_idx_o = fifo_head;
    else if (sel_bypass) alloc_block_idx_o = free_block_idx_i;
  end

  assign fifo_pop    = sel_fifo;
  assign fifo_push   = free_req_i & ~sel_bypass;
  assign fresh_cnt_d = fresh_cnt_q + {{ADDR_W{1'b0}}, sel_fresh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fresh_cnt_q <= '0;
    else        fresh_cnt_q <= fresh_cnt_d;
  end

  fl_fifo #(
    .DEPTH (NUM_BLOCKS),
    .WIDTH (ADDR_W),
    .PTR_W (ADDR_W)
  ) u_recycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (free_block_idx_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Full only matters inside the FIFO, where it drops a free from a double-free caller.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_free_list.sv
// Directed and randomized bench for free_list, checked against a queue-based model
// of the free-list rules (fresh indices first, then recycled in free order, then bypass).
module tb_free_list;
  import mem_pkg::*;

  localparam int N = NUM_BLOCKS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_req_i;
  logic       alloc_gnt_o;
  block_idx_t alloc_block_idx_o;
  logic       free_req_i;
  block_idx_t free_block_idx_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_fresh;
  block_idx_t m_fifo[$];
  block_idx_t m_held[$];

  always #5 clk = ~clk;

  free_list dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .alloc_req_i       (alloc_req_i),
    .alloc_gnt_o       (alloc_gnt_o),
    .alloc_block_idx_o (alloc_block_idx_o),
    .free_req_i        (free_req_i),
    .free_block_idx_i  (free_block_idx_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fresh = 0;
    m_fifo.delete();
    m_held.delete();
  endtask

  // One clock cycle: drive at posedge+1, compare at posedge+4, update model, return at next posedge+1.
  task automatic cycle(input logic req, input logic fr, input block_idx_t fidx,
                       output logic g, output block_idx_t idx);
    logic       eg;
    block_idx_t ei;
    bit         bypass;
    bit         full;
    alloc_req_i      = req;
    free_req_i       = fr;
    free_block_idx_i = fidx;
    eg = 1'b0; ei = '0; bypass = 1'b0;
    if (req) begin
      if (m_fresh < N) begin
        eg = 1'b1; ei = block_idx_t'(m_fresh);
      end else if (m_fifo.size() > 0) begin
        eg = 1'b1; ei = m_fifo[0];
      end else if (fr) begin
        eg = 1'b1; ei = fidx; bypass = 1'b1;
      end
    end
    #3;
    check("gnt", 32'(alloc_gnt_o), 32'(eg));
    check("idx", 32'(alloc_block_idx_o), 32'(ei));
    g   = alloc_gnt_o;
    idx = alloc_block_idx_o;
    full = (m_fifo.size() == N);
    if (fr) begin
      for (int k = 0; k < m_held.size(); k++)
        if (m_held[k] == fidx) begin
          m_held.delete(k);
          break;
        end
    end
    if (eg) begin
      if (m_fresh < N)       m_fresh++;
      else if (!bypass)      void'(m_fifo.pop_front());
      m_held.push_back(ei);
    end
    if (fr && !bypass && !full) m_fifo.push_back(fidx);
    @(posedge clk);
    #1;
    alloc_req_i = 1'b0;
    free_req_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_req_i = 1'b0;
    free_req_i  = 1'b0;
    free_block_idx_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(alloc_gnt_o), 32'd0);
    check("rst_idx", 32'(alloc_block_idx_o), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       g;
    block_idx_t i;
    block_idx_t pick;
    int         sel;

    do_reset();

    // Paced allocation of every block: expect 0..N-1 in order
    for (int k = 0; k < N; k++) begin
      cycle(1'b1, 1'b0, '0, g, i);
      if (k == 0 || k == N - 1) begin
        check("seq_gnt", 32'(g), 32'd1);
        check("seq_idx", 32'(i), 32'(k));
      end
      cycle(1'b0, 1'b0, '0, g, i);
    end

    // Exhausted list
    cycle(1'b1, 1'b0, '0, g, i);
    check("exh_gnt", 32'(g), 32'd0);

    // Free then reallocate a single block
    cycle(1'b0, 1'b1, block_idx_t'(2048), g, i);
    cycle(1'b1, 1'b0, '0, g, i);
    check("recyc_idx", 32'(i), 32'd2048);
    cycle(1'b1, 1'b0, '0, g, i);
    check("recyc_empty", 32'(g), 32'd0);

    // Bypass on an empty list must not leave anything queued
    cycle(1'b1, 1'b1, block_idx_t'(1200), g, i);
    check("byp_gnt", 32'(g), 32'd1);
    check("byp_idx", 32'(i), 32'd1200);
    cycle(1'b1, 1'b0, '0, g, i);
    check("byp_empty", 32'(g), 32'd0);

    // FIFO order, then simultaneous pop and push
    cycle(1'b0, 1'b1, block_idx_t'(5), g, i);
    cycle(1'b0, 1'b1, block_idx_t'(9), g, i);
    cycle(1'b0, 1'b1, block_idx_t'(3), g, i);
    cycle(1'b1, 1'b0, '0, g, i); check("fifo_a", 32'(i), 32'd5);
    cycle(1'b1, 1'b0, '0, g, i); check("fifo_b", 32'(i), 32'd9);
    cycle(1'b1, 1'b0, '0, g, i); check("fifo_c", 32'(i), 32'd3);
    cycle(1'b0, 1'b1, block_idx_t'(11), g, i);
    cycle(1'b1, 1'b1, block_idx_t'(7), g, i);
    check("pp_head", 32'(i), 32'd11);
    cycle(1'b1, 1'b0, '0, g, i);
    check("pp_next", 32'(i), 32'd7);

    // Mid-sequence asynchronous reset with a request held high
    do_reset();
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, '0, g, i);
    check("pre_rst_idx", 32'(i), 32'd9);
    alloc_req_i = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_gnt", 32'(alloc_gnt_o), 32'd0);
    check("async_idx", 32'(alloc_block_idx_o), 32'd0);
    @(posedge clk);
    #1;
    check("hold_gnt", 32'(alloc_gnt_o), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, '0, g, i);
      check("restart_idx", 32'(i), 32'(k));
    end

    // Randomized traffic after the fresh range is used up, freeing only held blocks
    do_reset();
    for (int k = 0; k < N; k++) cycle(1'b1, 1'b0, '0, g, i);
    for (int k = 0; k < 3000; k++) begin
      if (m_held.size() > 0 && ($urandom % 2) == 0) begin
        sel  = int'($urandom_range(m_held.size() - 1, 0));
        pick = m_held[sel];
        cycle(1'b1 && (($urandom % 3) != 0), 1'b1, pick, g, i);
      end else begin
        cycle(($urandom % 3) != 0, 1'b0, '0, g, i);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
